// File: rtl/div_seq.sv
// Sequential restoring divider: DIV/DIVU/REM/REMU, one quotient bit per RUN cycle.
// Optional macro DIV_SEQ_EARLY_EXIT_EN: divide-by-zero and signed overflow finish straight from LOAD.
module div_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Enable,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            busy
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      op_r;
  logic [XLEN-1:0] a_r, b_r;
  logic [XLEN-1:0] divisor, quo, rem;
  logic            q_neg, r_neg;
  logic [CW-1:0]   cnt;

  logic            is_signed, is_rem, div0, last_iter;
  logic [XLEN-1:0] a_mag, b_mag, q_fix, r_fix, diff;
  logic [XLEN:0]   rem_sh;
  logic            ge;

  assign is_signed = ~op_r[0];
  assign is_rem    = op_r[1];
  assign div0      = (b_r == '0);
  assign last_iter = (cnt == CW'(XLEN - 1));

  assign a_mag = (is_signed && a_r[XLEN-1]) ? -a_r : a_r;
  assign b_mag = (is_signed && b_r[XLEN-1]) ? -b_r : b_r;

  // Partial remainder is widened by one bit so the shift cannot lose its MSB.
  assign rem_sh = {rem, quo[XLEN-1]};
  assign ge     = (rem_sh >= {1'b0, divisor});
  assign diff   = rem_sh[XLEN-1:0] - divisor;

  // Quotient of x/0 stays all-ones regardless of operand signs.
  assign q_fix = (is_signed && q_neg && !div0) ? -quo : quo;
  assign r_fix = (is_signed && r_neg) ? -rem : rem;

`ifdef DIV_SEQ_EARLY_EXIT_EN
  logic            special;
  logic [XLEN-1:0] special_res;
  assign special = div0 ||
                   (is_signed && (a_r == {1'b1, {(XLEN-1){1'b0}}}) && (b_r == '1));
  always_comb begin
    special_res = '0;
    if (div0)
      special_res = is_rem ? a_r : '1;
    else
      special_res = is_rem ? '0 : a_r;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (Enable) state_nxt = LOAD;
      end
`ifdef DIV_SEQ_EARLY_EXIT_EN
      LOAD: state_nxt = special ? DONE : RUN;
`else
      LOAD: state_nxt = RUN;
`endif
      RUN:  if (last_iter) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_r    <= '0;
      a_r     <= '0;
      b_r     <= '0;
      divisor <= '0;
      quo     <= '0;
      rem     <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      cnt     <= '0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: if (Enable) begin
          op_r <= op;
          a_r  <= rs1;
          b_r  <= rs2;
        end
        LOAD: begin
          quo     <= a_mag;
          divisor <= b_mag;
          rem     <= '0;
          cnt     <= '0;
          q_neg   <= is_signed && (a_r[XLEN-1] ^ b_r[XLEN-1]);
          r_neg   <= is_signed && a_r[XLEN-1];
`ifdef DIV_SEQ_EARLY_EXIT_EN
          if (special) result <= special_res;
`endif
        end
        RUN: begin
          if (ge) begin
            rem <= diff;
            quo <= {quo[XLEN-2:0], 1'b1};
          end else begin
            rem <= rem_sh[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b0};
          end
          if (!last_iter) cnt <= cnt + CW'(1);
        end
        FIX: result <= is_rem ? r_fix : q_fix;
        default: ;
      endcase
    end
  end

endmodule
